// File: rtl/key_sw_mmio_if.sv
`default_nettype none
// ============================================================================
// Module   : key_sw_mmio_if
// Brief    : MEM-stage load/store port shared between the CPU and the
//            KEY/SW memory-mapped responder.
// Revision : 1.0 - initial release
// ============================================================================
interface key_sw_mmio_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] abus_in;
    logic             re_in;
    logic             we_in;
    logic [DBITS-1:0] dbus_in;
    logic [DBITS-1:0] dbus_out;
    logic             sel_out;

    // CPU side: drives address/strobes/store data, receives load data
    modport master (
        output abus_in, re_in, we_in, dbus_in,
        input  dbus_out, sel_out
    );

    // Device side
    modport slave (
        input  abus_in, re_in, we_in, dbus_in,
        output dbus_out, sel_out
    );
endinterface
`default_nettype wire

// File: rtl/key_sw_mmio.sv
`default_nettype none
// ============================================================================
// Module   : key_sw_mmio
// Brief    : KEY/SW device registers (data + control/status) with input
//            synchronisers, switch debouncing, sticky Ready/Overrun flags
//            and an interrupt request.
// Revision : 1.0 - initial release
// ============================================================================
module key_sw_mmio #(
    parameter int               DBITS        = 32,
    parameter int               KEYBITS      = 4,
    parameter int               SWBITS       = 10,
    parameter logic [DBITS-1:0] ADDRKDATA    = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRKCTRL    = 32'hFFFFF084,
    parameter logic [DBITS-1:0] ADDRSDATA    = 32'hFFFFF090,
    parameter logic [DBITS-1:0] ADDRSCTRL    = 32'hFFFFF094,
    parameter int               DEBOUNCE_CYC = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    key_sw_mmio_if.slave            bus,
    input  wire logic [KEYBITS-1:0] KEY,
    input  wire logic [SWBITS-1:0]  SW,
    output logic                    intr_out
);

    localparam int                 c_CNT_W   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYC - 1);

    // Address decode
    logic w_hit_kdata, w_hit_kctrl, w_hit_sdata, w_hit_sctrl, w_sel;
    assign w_hit_kdata = (bus.abus_in == ADDRKDATA);
    assign w_hit_kctrl = (bus.abus_in == ADDRKCTRL);
    assign w_hit_sdata = (bus.abus_in == ADDRSDATA);
    assign w_hit_sctrl = (bus.abus_in == ADDRSCTRL);
    assign w_sel       = w_hit_kdata | w_hit_kctrl | w_hit_sdata | w_hit_sctrl;

    // ---------------------------------------------------------------- KEY
    logic [KEYBITS-1:0] r_key_s1, r_key_s2, r_kdata;
    logic               r_k_rdy, r_k_ovr, r_k_ie;
    logic               w_k_ev, w_k_rdclr, w_k_wr, w_k_clr;

    assign w_k_ev    = (r_key_s2 != r_kdata);
    assign w_k_rdclr = bus.re_in & w_hit_kdata;
    assign w_k_wr    = bus.we_in & w_hit_kctrl;
    // Any access that clears Ready this edge also suppresses Overrun
    assign w_k_clr   = w_k_rdclr | (w_k_wr & ~bus.dbus_in[0]);

    // KEY synchroniser (inverted so pressed = 1), data capture and status
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_kdata  <= '0;
            r_k_rdy  <= 1'b0;
            r_k_ovr  <= 1'b0;
            r_k_ie   <= 1'b0;
        end else begin
            r_key_s1 <= ~KEY;
            r_key_s2 <= r_key_s1;
            r_kdata  <= r_key_s2;
            if (w_k_ev)
                r_k_rdy <= 1'b1;
            else if (w_k_clr)
                r_k_rdy <= 1'b0;
            if (w_k_ev & r_k_rdy & ~w_k_clr)
                r_k_ovr <= 1'b1;
            else if (w_k_wr & ~bus.dbus_in[2])
                r_k_ovr <= 1'b0;
            if (w_k_wr)
                r_k_ie <= bus.dbus_in[8];
        end
    end

    // ----------------------------------------------------------------- SW
    logic [SWBITS-1:0]  r_sw_s1, r_sw_s2, r_cand, r_sdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_s_rdy, r_s_ovr, r_s_ie;
    logic               w_s_ev, w_s_rdclr, w_s_wr, w_s_clr;

    // Candidate held long enough and differs from the accepted value
    assign w_s_ev    = (r_sw_s2 == r_cand) && (r_cnt == c_CNT_MAX) && (r_cand != r_sdata);
    assign w_s_rdclr = bus.re_in & w_hit_sdata;
    assign w_s_wr    = bus.we_in & w_hit_sctrl;
    assign w_s_clr   = w_s_rdclr | (w_s_wr & ~bus.dbus_in[0]);

    // SW synchroniser, debounce counter, data capture and status
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_sdata <= '0;
            r_s_rdy <= 1'b0;
            r_s_ovr <= 1'b0;
            r_s_ie  <= 1'b0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
            if (r_sw_s2 != r_cand) begin
                r_cand <= r_sw_s2;
                r_cnt  <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_s_ev)
                r_sdata <= r_cand;
            if (w_s_ev)
                r_s_rdy <= 1'b1;
            else if (w_s_clr)
                r_s_rdy <= 1'b0;
            if (w_s_ev & r_s_rdy & ~w_s_clr)
                r_s_ovr <= 1'b1;
            else if (w_s_wr & ~bus.dbus_in[2])
                r_s_ovr <= 1'b0;
            if (w_s_wr)
                r_s_ie <= bus.dbus_in[8];
        end
    end

    // ---------------------------------------------------------- Read path
    logic [DBITS-1:0] w_rdata;

    // Register select; values are the pre-edge state so a concurrent store
    // never shows up on the same cycle's load data
    always_comb begin
        w_rdata = '0;
        if (w_hit_kdata) begin
            w_rdata = DBITS'(r_kdata);
        end else if (w_hit_kctrl) begin
            w_rdata[0] = r_k_rdy;
            w_rdata[2] = r_k_ovr;
            w_rdata[8] = r_k_ie;
        end else if (w_hit_sdata) begin
            w_rdata = DBITS'(r_sdata);
        end else if (w_hit_sctrl) begin
            w_rdata[0] = r_s_rdy;
            w_rdata[2] = r_s_ovr;
            w_rdata[8] = r_s_ie;
        end
    end

    assign bus.sel_out  = w_sel;
    assign bus.dbus_out = (bus.re_in & w_sel) ? w_rdata : '0;
    assign intr_out     = (r_k_ie & r_k_rdy) | (r_s_ie & r_s_rdy);

    // Only bits 0, 2 and 8 of store data are meaningful
    logic w_unused;
    assign w_unused = ^bus.dbus_in;

endmodule
`default_nettype wire

// File: doc/key_sw_mmio.md
Name: key_sw_mmio

Overview:
- Memory-mapped responder for the processor's MEM-stage load/store port, owning KEY and SW.
- Replaces the bare KEY compare in the load path with four device registers: key data/control and switch data/control.
- Adds input synchronisation, switch debouncing, sticky Ready/Overrun status and an interrupt request.
- The CPU muxes `dbus_out` into its load data whenever `sel_out` is high.

Parameters:
- DBITS, 32, data/address bus width
- KEYBITS, 4, number of KEY inputs
- SWBITS, 10, number of SW inputs
- ADDRKDATA, 32'hFFFFF080, KEY data register address (read-only)
- ADDRKCTRL, 32'hFFFFF084, KEY control/status register address
- ADDRSDATA, 32'hFFFFF090, SW data register address (read-only)
- ADDRSCTRL, 32'hFFFFF094, SW control/status register address
- DEBOUNCE_CYC, 16, cycles a synchronised SW value must stay stable before acceptance (≥2)

Ports:
- clk, input, 1, system clock (PLL output)
- reset, input, 1, synchronous, active-high reset
- abus_in, input, DBITS, memory address from MEM stage (aluout_EX)
- re_in, input, 1, load in MEM stage
- we_in, input, 1, store in MEM stage
- dbus_in, input, DBITS, store data (regval2_EX)
- dbus_out, output, DBITS, load data; combinational
- sel_out, output, 1, abus_in matches one of the four addresses; combinational
- KEY, input, KEYBITS, raw push-buttons, active-low
- SW, input, SWBITS, raw slide switches
- intr_out, output, 1, interrupt request

Behaviour:
- Reset, checked on the clk edge only: all synchronisers, KDATA, SDATA, candidate, counter, Ready/Overrun/IE bits = 0; dbus_out = 0, intr_out = 0, sel_out follows abus_in.
- Synchronisers:
  - KEY: two flops on ~KEY, so pressed = 1.
  - SW: two flops.
  - Both are 2-edge latency to the "synced" value.
- KDATA:
  - Loads synced KEY every edge.
  - A "key event" is synced != KDATA at that edge.
  - Visible on reads 3 edges after a KEY pin change.
- KCTRL bits: bit0 Ready, bit2 Overrun, bit8 IE; other bits read 0.
  - Key event with Ready=0: Ready <= 1.
  - Key event with Ready=1 and no clearing access: Overrun <= 1.
  - Load from ADDRKDATA (re_in & addr match) clears Ready at that edge.
  - Load-clear and key event on the same edge: Ready stays 1, Overrun unchanged.
- KCTRL stores:
  - Ready and Overrun are write-0-to-clear; writing 1 has no effect.
  - IE takes dbus_in[8].
  - An event on the same edge as a write-0 wins: Ready = 1.
- SW debounce:
  - If synced SW != candidate: candidate <= synced, counter <= 0.
  - Otherwise counter increments, saturating at DEBOUNCE_CYC-1.
  - At an edge where synced == candidate, counter == DEBOUNCE_CYC-1 and candidate != SDATA: SDATA <= candidate. This is a "switch event".
  - Pin change held stable → SDATA updates on edge DEBOUNCE_CYC+3.
  - Bounce restarts the count.
- SCTRL: same bit layout and rules as KCTRL, driven by switch events and loads from ADDRSDATA.
- Stores to ADDRKDATA/ADDRSDATA are ignored.
- Read path:
  - If re_in & sel_out: dbus_out = zero-extended register value.
  - Otherwise dbus_out = 0.
  - A simultaneous store returns pre-store values.
- intr_out = (K.IE & K.Ready) | (S.IE & S.Ready), from registers with no extra latency.
- Unmapped addresses: sel_out = 0, no state change.
- Width: data registers zero-extended to DBITS; addresses compared on the full DBITS.

Test Plan:
- Reset with KEY=4'hF, SW=0; release; hold 10 cycles → KDATA=0, SDATA=0, KCTRL=0, SCTRL=0, intr_out=0.
- KEY drops to 4'b1110 → KDATA=32'h1 and KCTRL=32'h1 three edges later; load ADDRKDATA → returns 1, then KCTRL=0.
- KEY changes to 4'b1100, then 4'b1000 with no read → KCTRL=32'h5; store 0 to ADDRKCTRL → KCTRL=0.
- SW=10'h2AA with DEBOUNCE_CYC=16 → SDATA=0 through edge 18, 32'h2AA at edge 19; SW toggling every 5 cycles for 100 cycles → SDATA never changes.
- Store 32'h100 to ADDRSCTRL, then a stable SW change → intr_out rises with S.Ready; load ADDRSDATA → intr_out falls next edge.
- Key event on the same edge as a load of ADDRKDATA → Ready remains 1, Overrun 0; assert reset mid-debounce → counter, candidate and SDATA = 0 next edge.
